// File: rtl/count_compare_pkg.sv
// Shared definitions for count_compare: FSM state encodings, match-mode
// constants (same spellings the upstream counter uses) and a small helper.
package count_compare_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_FIRE  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam MM_EQ = "EQ";
   localparam MM_GE = "GE";
   localparam MM_LE = "LE";

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/count_match.sv
// Combinational unsigned comparator between the counter value and the armed
// threshold; the relation is fixed at elaboration by MATCH_MODE.
module count_match
   import count_compare_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter     MATCH_MODE = MM_EQ
) (
   input  logic [DATA_WIDTH-1:0] count,
   input  logic [DATA_WIDTH-1:0] thr,
   output logic                  hit
);

   generate
      if (MATCH_MODE == MM_GE) begin : g_ge
         // up-counters with STEP>1 may jump over thr
         assign hit = (count >= thr);
      end else if (MATCH_MODE == MM_LE) begin : g_le
         // down-counters with STEP>1 may jump over thr
         assign hit = (count <= thr);
      end else begin : g_eq
         assign hit = (count == thr);
      end
   endgenerate

endmodule

// File: rtl/count_compare.sv
// count_compare: watches a counter value and, once armed, fires a registered
// pulse of PULSE_WIDTH cycles on a match, optionally holds off, then re-arms
// or idles. Keeps a saturating count of fired events.
// Build option: COUNT_COMPARE_CAPTURE_EN adds output cap, the count value
// captured on each ARMED->FIRE edge.
module count_compare
   import count_compare_pkg::*;
#(
   parameter     ARCHITECTURE    = "BEHAVIORAL",
   parameter int DATA_WIDTH      = 8,
   parameter     MATCH_MODE      = MM_EQ,
   parameter int PULSE_WIDTH     = 1,
   parameter int HOLDOFF         = 4,
   parameter int REARM           = 1,
   parameter int EVENT_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [DATA_WIDTH-1:0]      count,
   input  logic [DATA_WIDTH-1:0]      thresh,
   input  logic                       arm,
   output logic                       o,
   output logic                       busy,
   output logic [EVENT_CNT_WIDTH-1:0] events
`ifdef COUNT_COMPARE_CAPTURE_EN
   ,
   output logic [DATA_WIDTH-1:0]      cap
`endif
);

   // PULSE_WIDTH=0 behaves as 1; using the effective width here also keeps
   // the timer at least one bit wide when both widths are zero.
   localparam int PW_EFF = (PULSE_WIDTH < 1) ? 1 : PULSE_WIDTH;
   localparam int CW     = $clog2(max_i(PW_EFF, HOLDOFF) + 1);
   localparam logic [CW-1:0] PW_LD = CW'(PW_EFF - 1);
   localparam logic [CW-1:0] HO_LD = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
   localparam bit IMPL    = (ARCHITECTURE == "BEHAVIORAL");
   localparam bit HAS_HO  = (HOLDOFF > 0);
   localparam bit DO_REARM = (REARM != 0);

   state_t                state, state_nxt;
   logic [CW-1:0]         tmr, tmr_nxt;
   logic [DATA_WIDTH-1:0] thr;
   logic                  hit;
   logic                  fire_start, o_nxt, busy_nxt;

   count_match #(
      .DATA_WIDTH (DATA_WIDTH),
      .MATCH_MODE (MATCH_MODE)
   ) u_match (
      .count (count),
      .thr   (thr),
      .hit   (hit)
   );

   // State, timer, registered outputs, threshold latch and event counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         tmr    <= '0;
         o      <= 1'b0;
         busy   <= 1'b0;
         thr    <= '0;
         events <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
         o     <= o_nxt;
         busy  <= busy_nxt;
         if (state == ST_IDLE && state_nxt == ST_ARMED)
            thr <= thresh;
         if (fire_start && events != {EVENT_CNT_WIDTH{1'b1}})
            events <= events + 1'b1;
      end
   end

   // Next state; tmr counts remaining cycles of the current FIRE/HOLD phase
   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      case (state)
         ST_IDLE:  if (arm) state_nxt = ST_ARMED;
         ST_ARMED: if (en && hit) begin
                      state_nxt = ST_FIRE;
                      tmr_nxt   = PW_LD;
                   end
         ST_FIRE:  if (tmr == '0) begin
                      if (HAS_HO) begin
                         state_nxt = ST_HOLD;
                         tmr_nxt   = HO_LD;
                      end else begin
                         state_nxt = DO_REARM ? ST_ARMED : ST_IDLE;
                      end
                   end else begin
                      tmr_nxt = tmr - 1'b1;
                   end
         ST_HOLD:  if (tmr == '0) state_nxt = DO_REARM ? ST_ARMED : ST_IDLE;
                   else           tmr_nxt   = tmr - 1'b1;
         default:  state_nxt = ST_IDLE;
      endcase
      // unimplemented architectures stay parked in reset state
      if (!IMPL) begin
         state_nxt = ST_IDLE;
         tmr_nxt   = '0;
      end
   end

   // Output decode from next state so o and busy register alongside state
   always_comb begin
      fire_start = (state == ST_ARMED) && (state_nxt == ST_FIRE);
      o_nxt      = (state_nxt == ST_FIRE);
      busy_nxt   = (state_nxt != ST_IDLE);
   end

`ifdef COUNT_COMPARE_CAPTURE_EN
   // Capture the counter value that triggered the most recent event
   always_ff @(posedge clk) begin
      if (rst)             cap <= '0;
      else if (fire_start) cap <= count;
   end
`else
   // no capture register in this build
`endif

endmodule
